// File: rtl/mul_pkg.sv
// Shared definitions for the iterative shift-and-add multiplier and its producers.
//   mul_state_t       : multiplier control states
//   MUL_WIDTH_DEFAULT : default operand width
//   twos_mag          : conditional two's-complement negation (magnitude of a signed operand)
package mul_pkg;

  localparam int unsigned MUL_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mul_state_t;

  // Magnitude of v when en marks it as signed; 0x80 maps to itself (unsigned 128).
  function automatic logic [MUL_WIDTH_DEFAULT-1:0] twos_mag(
    input logic [MUL_WIDTH_DEFAULT-1:0] v,
    input logic                         en
  );
    logic [MUL_WIDTH_DEFAULT-1:0] neg;
    neg = MUL_WIDTH_DEFAULT'(~v + MUL_WIDTH_DEFAULT'(1));
    return (en && v[MUL_WIDTH_DEFAULT-1]) ? neg : v;
  endfunction

endpackage

// File: rtl/shift_add_mul8.sv
// Iterative shift-and-add multiplier, unsigned or two's-complement signed.
// Ports:
//   clk, reset   : clock and synchronous active-high reset
//   mul_start    : level request, sampled in IDLE and DONE
//   mul_signed   : operands are two's complement (sampled with operands)
//   mul_ip_BA    : packed operands, B in upper half, A in lower half
//   mul_op_prod  : registered 2*WIDTH-bit product
//   mul_ready    : high while the product is presented (DONE)
//   mul_busy     : high while computing (ACC and FIX)
module shift_add_mul8
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mul_start,
  input  logic               mul_signed,
  input  logic [2*WIDTH-1:0] mul_ip_BA,
  output logic [2*WIDTH-1:0] mul_op_prod,
  output logic               mul_ready,
  output logic               mul_busy
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mul_state_t      state_q, state_d;
  logic [PW:0]     acc_q;
  logic [PW-1:0]   mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CW-1:0]   cnt_q;
  logic            sgn_q, neg_q;
  logic [PW-1:0]   prod_q;
  logic            ready_q, busy_q;

  logic [WIDTH-1:0] a_raw, b_raw, a_mag, b_mag;
  logic             last_iter;

  // Operand magnitudes at the sampling edge.
  always_comb begin
    a_raw = mul_ip_BA[WIDTH-1:0];
    b_raw = mul_ip_BA[PW-1:WIDTH];
    a_mag = (mul_signed && a_raw[WIDTH-1]) ? WIDTH'(~a_raw + WIDTH'(1)) : a_raw;
    b_mag = (mul_signed && b_raw[WIDTH-1]) ? WIDTH'(~b_raw + WIDTH'(1)) : b_raw;
  end

  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; ACC always runs exactly WIDTH cycles.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mul_start) state_d = ACC;
      ACC:     if (last_iter) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    if (!mul_start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: multiplicand shifts left, multiplier shifts right, one adder.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      sgn_q    <= 1'b0;
      neg_q    <= 1'b0;
      prod_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (mul_start) begin
          sgn_q    <= mul_signed;
          neg_q    <= mul_signed & (a_raw[WIDTH-1] ^ b_raw[WIDTH-1]);
          mcand_q  <= {WIDTH'(0), b_mag};
          mplier_q <= a_mag;
          acc_q    <= '0;
          cnt_q    <= '0;
        end
        ACC: begin
          if (mplier_q[0]) acc_q <= acc_q + {1'b0, mcand_q};
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= CW'(cnt_q + CW'(1));
        end
        FIX: prod_q <= (sgn_q && neg_q) ? PW'(~acc_q + (PW+1)'(1)) : acc_q[PW-1:0];
        default: ;
      endcase
    end
  end

  // Registered handshake flags track the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ready_q <= (state_d == DONE);
      busy_q  <= (state_d == ACC) || (state_d == FIX);
    end
  end

  assign mul_op_prod = prod_q;
  assign mul_ready   = ready_q;
  assign mul_busy    = busy_q;

endmodule

// File: tb/tb_shift_add_mul8.sv
// Directed bench for shift_add_mul8 (WIDTH=8) with hand-computed products.
module tb_shift_add_mul8;

  logic        clk;
  logic        reset;
  logic        mul_start;
  logic        mul_signed;
  logic [15:0] mul_ip_BA;
  logic [15:0] mul_op_prod;
  logic        mul_ready;
  logic        mul_busy;

  int n_vec;
  int n_err;
  int lat;
  logic [15:0] held;

  shift_add_mul8 #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .mul_start  (mul_start),
    .mul_signed (mul_signed),
    .mul_ip_BA  (mul_ip_BA),
    .mul_op_prod(mul_op_prod),
    .mul_ready  (mul_ready),
    .mul_busy   (mul_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Raise a request and return just after the sampling edge E0.
  task automatic start_op(input logic [15:0] ba, input logic sgn);
    @(negedge clk);
    mul_ip_BA  = ba;
    mul_signed = sgn;
    mul_start  = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Count edges after E0 until mul_ready, continuing from a given count.
  task automatic wait_ready(input int from, output int edges);
    edges = from;
    while (!mul_ready && edges < 30) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  // Full operation: start, check busy, latency and product.
  task automatic run_op(input string tag, input logic [15:0] ba, input logic sgn,
                        input logic [15:0] exp);
    int e;
    start_op(ba, sgn);
    chk({tag, "_busy"}, 32'(mul_busy), 32'd1);
    wait_ready(0, e);
    chk({tag, "_lat"}, 32'(e), 32'd9);
    chk({tag, "_prod"}, 32'(mul_op_prod), 32'(exp));
    chk({tag, "_busy_done"}, 32'(mul_busy), 32'd0);
  endtask

  // Drop the request in DONE; ready must clear on the next edge.
  task automatic release_op(input string tag);
    @(negedge clk);
    mul_start = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_rel"}, 32'(mul_ready), 32'd0);
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    reset      = 1'b1;
    mul_start  = 1'b0;
    mul_signed = 1'b0;
    mul_ip_BA  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_prod",  32'(mul_op_prod), 32'd0);
    chk("rst_ready", 32'(mul_ready),   32'd0);
    chk("rst_busy",  32'(mul_busy),    32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op("u_0c_0d", 16'h0D0C, 1'b0, 16'h009C); release_op("u_0c_0d");
    run_op("u_ff_ff", 16'hFFFF, 1'b0, 16'hFE01); release_op("u_ff_ff");
    run_op("s_ff_ff", 16'hFFFF, 1'b1, 16'h0001); release_op("s_ff_ff");
    run_op("s_80_7f", 16'h807F, 1'b1, 16'hC080); release_op("s_80_7f");
    run_op("s_80_80", 16'h8080, 1'b1, 16'h4000); release_op("s_80_80");
    run_op("u_00_a5", 16'hA500, 1'b0, 16'h0000); release_op("u_00_a5");
    run_op("s_05_fd", 16'hFD05, 1'b1, 16'hFFF1); release_op("s_05_fd");

    // Hold the request in DONE: no restart, product stable.
    run_op("hold", 16'h0D0C, 1'b0, 16'h009C);
    held = mul_op_prod;
    mul_ip_BA = 16'hFFFF;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk("hold_ready", 32'(mul_ready), 32'd1);
      chk("hold_prod",  32'(mul_op_prod), 32'(held));
    end
    chk("hold_busy", 32'(mul_busy), 32'd0);
    release_op("hold");
    run_op("u_02_03", 16'h0302, 1'b0, 16'h0006); release_op("u_02_03");

    // Request dropped and operands scrambled mid-run.
    start_op(16'h0D0C, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    mul_start  = 1'b0;
    mul_ip_BA  = 16'hFFFF;
    mul_signed = 1'b1;
    #1;
    wait_ready(3, lat);
    chk("drop_lat",  32'(lat), 32'd9);
    chk("drop_prod", 32'(mul_op_prod), 32'h009C);
    @(posedge clk);
    #1;
    chk("drop_pulse", 32'(mul_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("drop_idle_busy", 32'(mul_busy), 32'd0);

    // Reset mid-ACC with the request still high: reset wins.
    start_op(16'hFFFF, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_busy",  32'(mul_busy),    32'd0);
    chk("mrst_ready", 32'(mul_ready),   32'd0);
    chk("mrst_prod",  32'(mul_op_prod), 32'd0);
    @(posedge clk);
    #1;
    chk("mrst_hold_busy", 32'(mul_busy), 32'd0);
    @(negedge clk);
    reset     = 1'b0;
    mul_start = 1'b0;
    run_op("post_rst", 16'h0D0C, 1'b0, 16'h009C); release_op("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
